spram_rmw_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the team's single-port synchronous RAM (1-cycle registered read, read data forced to 0 when re is low).
- Converts a valid/ready CPU-style memory request with byte strobes into RAM re/we cycles. Partial-word stores are done as read-modify-write.
- Returns one response per request on a valid/ready channel, with one transaction outstanding.

---
 rtl/spram_pkg.sv | 22 ++
 rtl/byte_merge.sv | 21 ++
 rtl/spram_rmw_ctrl.sv | 116 +++++++++++
 tb/tb_spram_rmw_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Types and width helpers shared by the single-port RAM request controller
// and its byte-merge datapath.
package spram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_WR_ISSUE,
    ST_RESP
  } spram_ctrl_state_t;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // Byte-offset bits dropped from a byte address to form a word address.
  function automatic int off_bits(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Per-byte select between an old word and a new word under a byte-strobe
// mask; purely combinational.
module byte_merge
  import spram_pkg::*;
#(
  parameter int DataBusWidth = 32
) (
  input  logic [DataBusWidth-1:0]               i_old,
  input  logic [DataBusWidth-1:0]               i_new,
  input  logic [strb_width(DataBusWidth)-1:0]   i_strb,
  output logic [DataBusWidth-1:0]               o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < strb_width(DataBusWidth); i++) begin
      if (i_strb[i]) o_merged[i*8 +: 8] = i_new[i*8 +: 8];
    end
  end

endmodule

// File: rtl/spram_rmw_ctrl.sv
// Valid/ready request front end for the single-port synchronous RAM; partial
// stores become a read, a byte merge, then a write. One request in flight.
module spram_rmw_ctrl
  import spram_pkg::*;
#(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [AddrBusWidth-1:0]               req_addr,
  input  logic                                  req_we,
  input  logic [strb_width(DataBusWidth)-1:0]   req_wstrb,
  input  logic [DataBusWidth-1:0]               req_wdata,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DataBusWidth-1:0]               rsp_rdata,
  output logic                                  mem_re,
  output logic                                  mem_we,
  output logic [AddrBusWidth-1:0]               mem_addr,
  output logic [DataBusWidth-1:0]               mem_wdata,
  input  logic [DataBusWidth-1:0]               mem_rdata
);

  localparam int StrbWidth = strb_width(DataBusWidth);
  localparam int OffBits   = off_bits(DataBusWidth);
  localparam logic [AddrBusWidth-1:0] AddrMask =
    ~((AddrBusWidth)'((1 << OffBits) - 1));

  spram_ctrl_state_t           r_state;
  spram_ctrl_state_t           w_next;
  logic [AddrBusWidth-1:0]     r_addr;
  logic [StrbWidth-1:0]        r_wstrb;
  logic [DataBusWidth-1:0]     r_wdata;
  logic [DataBusWidth-1:0]     r_rdata;
  logic                        r_rmw;
  logic [DataBusWidth-1:0]     w_merged;
  logic                        w_fire;
  logic                        w_strb_all;
  logic                        w_strb_none;

  byte_merge #(
    .DataBusWidth(DataBusWidth)
  ) u_merge (
    .i_old    (mem_rdata),
    .i_new    (r_wdata),
    .i_strb   (r_wstrb),
    .o_merged (w_merged)
  );

  // rst gates ready so nothing can be accepted while reset is held.
  assign req_ready   = (r_state == ST_IDLE) && !rst;
  assign w_fire      = req_valid && req_ready;
  assign w_strb_all  = &req_wstrb;
  assign w_strb_none = ~|req_wstrb;

  assign mem_re    = (r_state == ST_RD_ISSUE);
  assign mem_we    = (r_state == ST_WR_ISSUE);
  assign rsp_valid = (r_state == ST_RESP);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_rdata = r_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          if (!req_we)          w_next = ST_RD_ISSUE;
          else if (w_strb_all)  w_next = ST_WR_ISSUE;
          else if (w_strb_none) w_next = ST_RESP;
          else                  w_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE:   w_next = ST_RD_CAPTURE;
      ST_RD_CAPTURE: w_next = r_rmw ? ST_WR_ISSUE : ST_RESP;
      ST_WR_ISSUE:   w_next = ST_RESP;
      ST_RESP:       if (rsp_ready) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rmw   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_addr  <= req_addr & AddrMask;
            r_wstrb <= req_wstrb;
            r_wdata <= req_wdata;
            // Cleared here so a zero-strobe store never returns stale load data.
            r_rdata <= '0;
            r_rmw   <= req_we && !w_strb_all && !w_strb_none;
          end
        end
        ST_RD_CAPTURE: begin
          if (r_rmw) r_wdata <= w_merged;
          else       r_rdata <= mem_rdata;
        end
        ST_WR_ISSUE: r_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_rmw_ctrl.sv
// Directed bench for spram_rmw_ctrl with a behavioural single-port RAM model.
module tb_spram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spram_rmw_ctrl #(.AddrBusWidth(32), .DataBusWidth(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM model: registered read, read data zero when re is low.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem_re ? ram[mem_addr[7:2]] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE; returns in cycle T+1 with req_valid dropped.
  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] s,
                       input logic [31:0] d);
    req_addr  = a;
    req_we    = we;
    req_wstrb = s;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[6'h04] = 32'hDEADBEEF;
    ram[6'h10] = 32'hAABBCCDD;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wstrb = '0; req_wdata = '0; rsp_ready = 1'b0;

    tick(); tick();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mem_re",    {31'h0, mem_re},    32'h0);
    chk("rst_mem_we",    {31'h0, mem_we},    32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_mem_wdata", mem_wdata,          32'h0);
    chk("rst_rsp_rdata", rsp_rdata,          32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Load from 0x10
    rsp_ready = 1'b1;
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    chk("ld_T1_re",    {31'h0, mem_re}, 32'h1);
    chk("ld_T1_addr",  mem_addr,        32'h10);
    chk("ld_T1_we",    {31'h0, mem_we}, 32'h0);
    chk("ld_T1_ready", {31'h0, req_ready}, 32'h0);
    tick();
    chk("ld_T2_re",    {31'h0, mem_re}, 32'h0);
    chk("ld_T2_rv",    {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("ld_T3_rv",    {31'h0, rsp_valid}, 32'h1);
    chk("ld_T3_data",  rsp_rdata,       32'hDEADBEEF);
    chk("ld_T3_we",    {31'h0, mem_we}, 32'h0);
    tick();
    chk("ld_T4_rv",    {31'h0, rsp_valid}, 32'h0);
    chk("ld_T4_ready", {31'h0, req_ready}, 32'h1);

    // Full store to 0x23
    issue(32'h23, 1'b1, 4'hF, 32'h12345678);
    chk("fs_T1_we",    {31'h0, mem_we}, 32'h1);
    chk("fs_T1_re",    {31'h0, mem_re}, 32'h0);
    chk("fs_T1_addr",  mem_addr,        32'h20);
    chk("fs_T1_wdata", mem_wdata,       32'h12345678);
    tick();
    chk("fs_T2_rv",    {31'h0, rsp_valid}, 32'h1);
    chk("fs_T2_data",  rsp_rdata,       32'h0);
    chk("fs_T2_we",    {31'h0, mem_we}, 32'h0);
    tick();
    chk("fs_ram",      ram[6'h08],      32'h12345678);
    chk("fs_T3_ready", {31'h0, req_ready}, 32'h1);

    // Partial store to 0x40, strobe 0101
    issue(32'h40, 1'b1, 4'b0101, 32'h11223344);
    chk("ps_T1_re",    {31'h0, mem_re}, 32'h1);
    chk("ps_T1_we",    {31'h0, mem_we}, 32'h0);
    tick();
    chk("ps_T2_re",    {31'h0, mem_re}, 32'h0);
    chk("ps_T2_we",    {31'h0, mem_we}, 32'h0);
    tick();
    chk("ps_T3_we",    {31'h0, mem_we}, 32'h1);
    chk("ps_T3_re",    {31'h0, mem_re}, 32'h0);
    chk("ps_T3_addr",  mem_addr,        32'h40);
    chk("ps_T3_wdata", mem_wdata,       32'hAA22CC44);
    chk("ps_T3_rv",    {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("ps_T4_rv",    {31'h0, rsp_valid}, 32'h1);
    chk("ps_T4_data",  rsp_rdata,       32'h0);
    tick();
    issue(32'h40, 1'b0, 4'h0, 32'h0);
    tick(); tick();
    chk("ps_readback_rv",   {31'h0, rsp_valid}, 32'h1);
    chk("ps_readback_data", rsp_rdata,          32'hAA22CC44);
    tick();

    // Zero-strobe store: immediate response, no RAM access
    issue(32'h40, 1'b1, 4'h0, 32'hFFFFFFFF);
    chk("zs_T1_rv",   {31'h0, rsp_valid}, 32'h1);
    chk("zs_T1_data", rsp_rdata,          32'h0);
    chk("zs_T1_re",   {31'h0, mem_re},    32'h0);
    chk("zs_T1_we",   {31'h0, mem_we},    32'h0);
    tick();
    chk("zs_T2_ready", {31'h0, req_ready}, 32'h1);
    chk("zs_T2_we",    {31'h0, mem_we},    32'h0);
    chk("zs_ram",      ram[6'h10],         32'hAA22CC44);

    // Load with consumer back-pressure for 5 cycles
    rsp_ready = 1'b0;
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rv",    {31'h0, rsp_valid}, 32'h1);
      chk("bp_data",  rsp_rdata,          32'hDEADBEEF);
      chk("bp_ready", {31'h0, req_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_same_cycle", {31'h0, req_ready}, 32'h0);
    tick();
    chk("bp_release_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_release_rv",    {31'h0, rsp_valid}, 32'h0);

    // Partial store aborted by reset in the read-capture cycle
    issue(32'h40, 1'b1, 4'b0011, 32'hFFFFFFFF);
    chk("ab_T1_re", {31'h0, mem_re}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("ab_rst_we",    {31'h0, mem_we},    32'h0);
    chk("ab_rst_rv",    {31'h0, rsp_valid}, 32'h0);
    chk("ab_rst_ready", {31'h0, req_ready}, 32'h0);
    rst = 1'b0;
    tick();
    chk("ab_post_ready", {31'h0, req_ready}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      chk("ab_idle_we", {31'h0, mem_we},    32'h0);
      chk("ab_idle_rv", {31'h0, rsp_valid}, 32'h0);
      tick();
    end
    chk("ab_ram", ram[6'h10], 32'hAA22CC44);
    issue(32'h40, 1'b0, 4'h0, 32'h0);
    tick(); tick();
    chk("ab_readback_rv",   {31'h0, rsp_valid}, 32'h1);
    chk("ab_readback_data", rsp_rdata,          32'hAA22CC44);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
